// File: rtl/dmem_arb_if.sv
// Bus bundle for dmem_arb: core port, external loader/debug port, memory port
// and a state debug tap.
interface dmem_arb_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_ad;
    logic [DW-1:0] c_wd;
    logic [DW-1:0] c_rd;
    logic          c_done;
    logic          c_stall;

    logic          x_req;
    logic          x_we;
    logic [AW-1:0] x_ad;
    logic [DW-1:0] x_wd;
    logic [DW-1:0] x_rd;
    logic          x_ack;

    logic          m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rd;

    logic [2:0]    dbg_state;

    modport slave (
        input  c_req, c_we, c_ad, c_wd,
        input  x_req, x_we, x_ad, x_wd,
        input  m_rd,
        output c_rd, c_done, c_stall,
        output x_rd, x_ack,
        output m_we, m_ad, m_wd,
        output dbg_state
    );

    modport master (
        output c_req, c_we, c_ad, c_wd,
        output x_req, x_we, x_ad, x_wd,
        output m_rd,
        input  c_rd, c_done, c_stall,
        input  x_rd, x_ack,
        input  m_we, m_ad, m_wd,
        input  dbg_state
    );
endinterface

// File: rtl/dmem_arb.sv
// Two-requester arbiter (core, external) in front of a single-port synchronous
// data memory. One access at a time, alternating grants under contention.
module dmem_arb #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input logic        clk,
    input logic        rst,
    dmem_arb_if.slave  bus
);

    // Handshake: a requester raises req; it is sampled only in IDLE. Once
    // granted, we/ad/wd are latched and req may drop. Completion is a
    // one-cycle done/ack pulse two cycles after the grant; read data is on
    // c_rd/x_rd in that cycle and held until the next completed read.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CACC = 3'd1,
        CRSP = 3'd2,
        XACC = 3'd3,
        XRSP = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          last_x;
    logic          grant_c;
    logic          grant_x;
    logic          l_we;
    logic [AW-1:0] l_ad;
    logic [DW-1:0] l_wd;
    logic [DW-1:0] c_rd_q;
    logic [DW-1:0] x_rd_q;
    logic          acc;

    always_comb begin
        state_nx = state;
        grant_c  = 1'b0;
        grant_x  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.c_req && (!bus.x_req || last_x)) begin
                    grant_c  = 1'b1;
                    state_nx = CACC;
                end else if (bus.x_req) begin
                    grant_x  = 1'b1;
                    state_nx = XACC;
                end
            end
            CACC:    state_nx = CRSP;
            CRSP:    state_nx = IDLE;
            XACC:    state_nx = XRSP;
            XRSP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_x <= 1'b1;
            l_we   <= 1'b0;
            l_ad   <= '0;
            l_wd   <= '0;
            c_rd_q <= '0;
            x_rd_q <= '0;
        end else begin
            state <= state_nx;
            if (grant_c) begin
                last_x <= 1'b0;
                l_we   <= bus.c_we;
                l_ad   <= bus.c_ad;
                l_wd   <= bus.c_wd;
            end else if (grant_x) begin
                last_x <= 1'b1;
                l_we   <= bus.x_we;
                l_ad   <= bus.x_ad;
                l_wd   <= bus.x_wd;
            end
            if (state == CRSP && !l_we) c_rd_q <= bus.m_rd;
            if (state == XRSP && !l_we) x_rd_q <= bus.m_rd;
        end
    end

    // rst gates the access cycle so a reset landing in CACC/XACC cannot
    // commit a write at the same edge that clears the FSM.
    assign acc = (state == CACC || state == XACC) && !rst;

    assign bus.m_we  = acc & l_we;
    assign bus.m_ad  = acc ? l_ad : '0;
    assign bus.m_wd  = acc ? l_wd : '0;

    assign bus.c_done  = (state == CRSP);
    assign bus.x_ack   = (state == XRSP);
    assign bus.c_stall = bus.c_req & ~bus.c_done;

    // Memory data is forwarded in the done cycle, then held by the register.
    assign bus.c_rd = (state == CRSP && !l_we) ? bus.m_rd : c_rd_q;
    assign bus.x_rd = (state == XRSP && !l_we) ? bus.m_rd : x_rd_q;

    assign bus.dbg_state = state;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb with a behavioural synchronous memory and
// per-port expected-read-data queues.
module tb_dmem_arb;

    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;

    always #5 clk = ~clk;

    dmem_arb_if #(.DW(DW), .AW(AW)) bus ();

    dmem_arb #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            bus.m_rd <= '0;
        end else begin
            if (bus.m_we) mem[bus.m_ad] <= bus.m_wd;
            bus.m_rd <= mem[bus.m_ad];
        end
    end

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] c_exp_q[$];
    logic [DW-1:0] x_exp_q[$];
    logic [DW-1:0] exp_v;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_ad = '0; bus.c_wd = '0;
        bus.x_req = 1'b0; bus.x_we = 1'b0; bus.x_ad = '0; bus.x_wd = '0;
    endtask

    task automatic drive_c(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        bus.c_req = 1'b1; bus.c_we = we; bus.c_ad = ad; bus.c_wd = wd;
    endtask

    task automatic drive_x(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        bus.x_req = 1'b1; bus.x_we = we; bus.x_ad = ad; bus.x_wd = wd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (bus.dbg_state !== 3'd0) begin
            errors++; $display("FAIL reset_state got %0d want 0", bus.dbg_state);
        end
        checks++;
        if ({bus.c_done, bus.x_ack, bus.m_we, bus.c_stall} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {bus.c_done, bus.x_ack, bus.m_we, bus.c_stall});
        end
        checks++;
        if ({bus.m_ad, bus.m_wd, bus.c_rd, bus.x_rd} !== '0) begin
            errors++; $display("FAIL reset_data got ad=%h wd=%h crd=%h xrd=%h want 0", bus.m_ad, bus.m_wd, bus.c_rd, bus.x_rd);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_core_write;
        drive_c(1'b1, 8'h10, 16'h1234);
        c_exp_q.push_back(16'h0000);
        #1;
        checks++;
        if (bus.c_stall !== 1'b1) begin
            errors++; $display("FAIL cw_stall_t0 got %b want 1", bus.c_stall);
        end
        tick();
        checks++;
        if ({bus.m_we, bus.m_ad, bus.m_wd, bus.c_stall, bus.c_done} !== {1'b1, 8'h10, 16'h1234, 1'b1, 1'b0}) begin
            errors++; $display("FAIL cw_access got we=%b ad=%h wd=%h stall=%b done=%b want 1 10 1234 1 0",
                               bus.m_we, bus.m_ad, bus.m_wd, bus.c_stall, bus.c_done);
        end
        tick();
        checks++;
        if ({bus.c_done, bus.c_stall, bus.m_we} !== 3'b100) begin
            errors++; $display("FAIL cw_done got done=%b stall=%b we=%b want 1 0 0", bus.c_done, bus.c_stall, bus.m_we);
        end
        if (bus.c_done === 1'b1 && c_exp_q.size() > 0) begin
            exp_v = c_exp_q.pop_front();
            checks++;
            if (bus.c_rd !== exp_v) begin
                errors++; $display("FAIL cw_rd_hold got %h want %h", bus.c_rd, exp_v);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (mem[8'h10] !== 16'h1234 || bus.c_done !== 1'b0) begin
            errors++; $display("FAIL cw_mem got mem=%h done=%b want 1234 0", mem[8'h10], bus.c_done);
        end
    endtask

    task automatic test_core_read;
        drive_c(1'b0, 8'h10, 16'hFFFF);
        c_exp_q.push_back(16'h1234);
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (cyc > 0) tick();
            checks++;
            if (bus.m_we !== 1'b0) begin
                errors++; $display("FAIL cr_we cyc=%0d got %b want 0", cyc, bus.m_we);
            end
        end
        checks++;
        if (bus.c_done !== 1'b1) begin
            errors++; $display("FAIL cr_done got %b want 1", bus.c_done);
        end else if (c_exp_q.size() > 0) begin
            exp_v = c_exp_q.pop_front();
            checks++;
            if (bus.c_rd !== exp_v) begin
                errors++; $display("FAIL cr_rd got %h want %h", bus.c_rd, exp_v);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.c_rd !== 16'h1234 || bus.c_done !== 1'b0) begin
            errors++; $display("FAIL cr_hold got rd=%h done=%b want 1234 0", bus.c_rd, bus.c_done);
        end
    endtask

    task automatic test_withdraw;
        drive_x(1'b1, 8'h20, 16'hBEEF);
        x_exp_q.push_back(16'h0000);
        tick();
        drive_x(1'b0, 8'hFF, 16'h0000);
        bus.x_req = 1'b0;
        #1;
        checks++;
        if ({bus.m_we, bus.m_ad, bus.m_wd} !== {1'b1, 8'h20, 16'hBEEF}) begin
            errors++; $display("FAIL xw_access got we=%b ad=%h wd=%h want 1 20 beef", bus.m_we, bus.m_ad, bus.m_wd);
        end
        tick();
        checks++;
        if (bus.x_ack !== 1'b1) begin
            errors++; $display("FAIL xw_ack got %b want 1", bus.x_ack);
        end else if (x_exp_q.size() > 0) begin
            exp_v = x_exp_q.pop_front();
            checks++;
            if (bus.x_rd !== exp_v) begin
                errors++; $display("FAIL xw_rd_hold got %h want %h", bus.x_rd, exp_v);
            end
        end
        tick();
        drive_x(1'b0, 8'h20, 16'h0000);
        x_exp_q.push_back(16'hBEEF);
        tick();
        bus.x_req = 1'b0;
        tick();
        checks++;
        if (bus.x_ack !== 1'b1) begin
            errors++; $display("FAIL xr_ack got %b want 1", bus.x_ack);
        end else if (x_exp_q.size() > 0) begin
            exp_v = x_exp_q.pop_front();
            checks++;
            if (bus.x_rd !== exp_v) begin
                errors++; $display("FAIL xr_rd got %h want %h", bus.x_rd, exp_v);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_contention;
        logic [1:0] side_q[$];
        logic [1:0] exp_side;
        int pulses;
        pulses = 0;
        for (int k = 0; k < 2; k++) begin
            side_q.push_back(2'b10); c_exp_q.push_back(16'h1234);
            side_q.push_back(2'b01); x_exp_q.push_back(16'hBEEF);
        end
        rst = 1'b1;
        drive_c(1'b0, 8'h10, 16'h0000);
        drive_x(1'b0, 8'h20, 16'h0000);
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.c_rd, bus.x_rd} !== '0) begin
            errors++; $display("FAIL ct_reset_rd got crd=%h xrd=%h want 0", bus.c_rd, bus.x_rd);
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc > 0) tick();
            if ((bus.c_done === 1'b1 || bus.x_ack === 1'b1) && side_q.size() > 0) begin
                exp_side = side_q.pop_front();
                checks++;
                if ({bus.c_done, bus.x_ack} !== exp_side) begin
                    errors++; $display("FAIL ct_order pulse=%0d got %b want %b", pulses, {bus.c_done, bus.x_ack}, exp_side);
                end
                checks++;
                if (cyc != 2 + 3 * pulses) begin
                    errors++; $display("FAIL ct_timing pulse=%0d got cycle %0d want %0d", pulses, cyc, 2 + 3 * pulses);
                end
                if (bus.c_done === 1'b1 && c_exp_q.size() > 0) begin
                    exp_v = c_exp_q.pop_front();
                    checks++;
                    if (bus.c_rd !== exp_v) begin
                        errors++; $display("FAIL ct_crd got %h want %h", bus.c_rd, exp_v);
                    end
                end else if (bus.x_ack === 1'b1 && x_exp_q.size() > 0) begin
                    exp_v = x_exp_q.pop_front();
                    checks++;
                    if (bus.x_rd !== exp_v) begin
                        errors++; $display("FAIL ct_xrd got %h want %h", bus.x_rd, exp_v);
                    end
                end
                pulses++;
                if (pulses == 4) idle_inputs();
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL ct_pulses got %0d want 4", pulses);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        drive_c(1'b1, 8'h30, 16'hDEAD);
        tick();
        rst = 1'b1;
        bus.c_req = 1'b0;
        #1;
        checks++;
        if (bus.m_we !== 1'b0) begin
            errors++; $display("FAIL rm_we_gate got %b want 0", bus.m_we);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.dbg_state !== 3'd0) begin
            errors++; $display("FAIL rm_state got %0d want 0", bus.dbg_state);
        end
        checks++;
        if ({bus.c_done, bus.x_ack, bus.m_we, bus.c_stall, bus.m_ad, bus.m_wd, bus.c_rd, bus.x_rd} !== '0) begin
            errors++; $display("FAIL rm_outputs got done=%b ack=%b we=%b stall=%b ad=%h wd=%h crd=%h xrd=%h want 0",
                               bus.c_done, bus.x_ack, bus.m_we, bus.c_stall, bus.m_ad, bus.m_wd, bus.c_rd, bus.x_rd);
        end
        tick();
        checks++;
        if (mem[8'h30] !== 16'h0000 || bus.c_done !== 1'b0) begin
            errors++; $display("FAIL rm_mem got mem=%h done=%b want 0000 0", mem[8'h30], bus.c_done);
        end
    endtask

    task automatic test_held;
        logic exp_done;
        logic [AW-1:0] exp_ad;
        drive_c(1'b0, 8'h10, 16'h0000);
        c_exp_q.push_back(16'h1234);
        c_exp_q.push_back(16'h1234);
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) tick();
            exp_done = (cyc == 2 || cyc == 5);
            exp_ad   = (cyc == 1 || cyc == 4) ? 8'h10 : 8'h00;
            checks++;
            if (bus.c_done !== exp_done || bus.m_ad !== exp_ad) begin
                errors++; $display("FAIL held cyc=%0d got done=%b ad=%h want %b %h", cyc, bus.c_done, bus.m_ad, exp_done, exp_ad);
            end
            if (bus.c_done === 1'b1 && c_exp_q.size() > 0) begin
                exp_v = c_exp_q.pop_front();
                checks++;
                if (bus.c_rd !== exp_v) begin
                    errors++; $display("FAIL held_rd cyc=%0d got %h want %h", cyc, bus.c_rd, exp_v);
                end
            end
            if (cyc == 5) idle_inputs();
        end
    endtask

    initial begin
        mem_clr = 1'b1;
        rst = 1'b1;
        idle_inputs();
        tick();
        mem_clr = 1'b0;
        test_reset();
        test_core_write();
        test_core_read();
        test_withdraw();
        test_contention();
        test_reset_mid();
        test_held();
        checks++;
        if (c_exp_q.size() != 0 || x_exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got c=%0d x=%0d want 0 0", c_exp_q.size(), x_exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
